// File: rtl/mips_cu_fsm.sv
// mips_cu_fsm: multi-cycle MIPS control unit FSM; define CU_INTR_EN to add the interrupt-entry state
module mips_cu_fsm #(
  parameter int FS_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     IR,
  input  logic            N,
  input  logic            Z,
  input  logic            C,
  input  logic            V,
  input  logic            intr,
  output logic [1:0]      pc_sel,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            im_cs,
  output logic            im_rd,
  output logic            ir_ld,
  output logic            D_En,
  output logic [1:0]      DA_sel,
  output logic            T_sel,
  output logic [1:0]      Y_sel,
  output logic [FS_W-1:0] FS,
  output logic            dm_cs,
  output logic            dm_rd,
  output logic            dm_wr,
  output logic            halted,
  output logic            illegal,
  output logic            int_ack
);
  localparam logic [4:0] FS_PASS = 5'h00, FS_ADD = 5'h02, FS_ADDU = 5'h03, FS_SUB = 5'h04,
                         FS_SUBU = 5'h05, FS_SLT = 5'h06, FS_SLTU = 5'h07, FS_AND = 5'h08,
                         FS_OR = 5'h09, FS_XOR = 5'h0A, FS_NOR = 5'h0B, FS_LUI = 5'h0C;
  typedef enum logic [4:0] {
    INIT, FETCH, DECODE, R_EX, R_WB, I_EX, I_WB, LW_EX, LW_RD, LW_WB,
    SW_EX, SW_WR, BR_EX, BR_TK, JMP, JR, HALT, ILL
`ifdef CU_INTR_EN
    , INTR
`endif
  } state_t;
  state_t state, nxt, dec, done;
  logic [5:0] op, fn;
  logic [4:0] r_fs, i_fs, fs_c;
  logic r_ok, taken, unused;
  assign op = IR[31:26];
  assign fn = IR[5:0];
  assign taken = IR[26] ? ~Z : Z;
  assign FS = FS_W'(fs_c);
  assign unused = ^{N, C, V, IR[25:6], intr};
`ifdef CU_INTR_EN
  assign done = intr ? INTR : FETCH;
`else
  assign done = FETCH;
`endif
  // State register; reset low drops straight to INIT regardless of the clock
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= INIT;
    else state <= nxt;
  // ALU codes for R-type funct and I-type opcode; r_ok marks the R-type ALU subset
  always_comb begin
    r_fs = FS_PASS;
    r_ok = 1'b1;
    case (fn)
      6'h20: r_fs = FS_ADD;
      6'h21: r_fs = FS_ADDU;
      6'h22: r_fs = FS_SUB;
      6'h23: r_fs = FS_SUBU;
      6'h24: r_fs = FS_AND;
      6'h25: r_fs = FS_OR;
      6'h26: r_fs = FS_XOR;
      6'h27: r_fs = FS_NOR;
      6'h2A: r_fs = FS_SLT;
      6'h2B: r_fs = FS_SLTU;
      default: r_ok = 1'b0;
    endcase
    i_fs = op == 6'h08 ? FS_ADD : op == 6'h0C ? FS_AND : op == 6'h0D ? FS_OR :
           op == 6'h0F ? FS_LUI : FS_PASS;
  end
  // Instruction class chosen in DECODE; anything unrecognised traps to ILL
  always_comb begin
    case (op)
      6'h00: dec = fn == 6'h08 ? JR : fn == 6'h0D ? HALT : r_ok ? R_EX : ILL;
      6'h08, 6'h0C, 6'h0D, 6'h0F: dec = I_EX;
      6'h23: dec = LW_EX;
      6'h2B: dec = SW_EX;
      6'h04, 6'h05: dec = BR_EX;
      6'h02: dec = JMP;
      default: dec = ILL;
    endcase
  end
  // Next state and Moore strobes; everything idles at 0 unless the state asserts it
  always_comb begin
    nxt = state;
    pc_sel = 2'b00;
    pc_ld = 1'b0;
    pc_inc = 1'b0;
    im_cs = 1'b0;
    im_rd = 1'b0;
    ir_ld = 1'b0;
    D_En = 1'b0;
    DA_sel = 2'b00;
    T_sel = 1'b0;
    Y_sel = 2'b00;
    fs_c = FS_PASS;
    dm_cs = 1'b0;
    dm_rd = 1'b0;
    dm_wr = 1'b0;
    halted = 1'b0;
    illegal = 1'b0;
    int_ack = 1'b0;
    case (state)
      INIT: nxt = FETCH;
      FETCH: begin
        {im_cs, im_rd, ir_ld, pc_inc} = 4'b1111;
        nxt = DECODE;
      end
      DECODE: nxt = dec;
      R_EX: begin
        fs_c = r_fs;
        nxt = R_WB;
      end
      R_WB: begin
        fs_c = r_fs;
        D_En = 1'b1;
        nxt = done;
      end
      I_EX: begin
        fs_c = i_fs;
        T_sel = 1'b1;
        nxt = I_WB;
      end
      I_WB: begin
        fs_c = i_fs;
        T_sel = 1'b1;
        D_En = 1'b1;
        DA_sel = 2'b01;
        nxt = done;
      end
      LW_EX: begin
        fs_c = FS_ADD;
        T_sel = 1'b1;
        nxt = LW_RD;
      end
      LW_RD: begin
        {dm_cs, dm_rd} = 2'b11;
        nxt = LW_WB;
      end
      LW_WB: begin
        {dm_cs, dm_rd, D_En} = 3'b111;
        DA_sel = 2'b01;
        Y_sel = 2'b01;
        nxt = done;
      end
      SW_EX: begin
        fs_c = FS_ADD;
        T_sel = 1'b1;
        nxt = SW_WR;
      end
      SW_WR: begin
        {dm_cs, dm_wr} = 2'b11;
        nxt = done;
      end
      BR_EX: begin
        fs_c = FS_SUB;
        nxt = BR_TK;
      end
      BR_TK: begin
        pc_ld = taken;
        nxt = done;
      end
      JMP: begin
        pc_ld = 1'b1;
        pc_sel = 2'b01;
        nxt = done;
      end
      JR: begin
        pc_ld = 1'b1;
        pc_sel = 2'b10;
        nxt = done;
      end
      HALT: halted = 1'b1;
      ILL: {illegal, halted} = 2'b11;
`ifdef CU_INTR_EN
      INTR: begin
        int_ack = 1'b1;
        D_En = 1'b1;
        DA_sel = 2'b10;
        Y_sel = 2'b10;
        pc_ld = 1'b1;
        pc_sel = 2'b10;
        nxt = FETCH;
      end
`endif
      default: nxt = INIT;
    endcase
  end
endmodule
